// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, transfer-direction constants and bit-counter width
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam int   CNT_W     = 3;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF pin synchronizers with SCL edge and START/STOP detection
module i2c_line_sync (
    input  logic clk,
    input  logic rstn,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [1:0] scl_ff, sda_ff;
    logic       scl_p, sda_p;
    logic       scl;
    // synchronize both pins and keep the previous synchronized level; reset to idle-high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_p  <= 1'b1;
            sda_p  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl_in};
            sda_ff <= {sda_ff[0], sda_in};
            scl_p  <= scl_ff[1];
            sda_p  <= sda_ff[1];
        end
    end
    assign scl      = scl_ff[1];
    assign sda      = sda_ff[1];
    assign scl_rise = scl & ~scl_p;
    assign scl_fall = ~scl & scl_p;
    assign start    = scl & scl_p & sda_p & ~sda;
    assign stop     = scl & scl_p & ~sda_p & sda;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: single-address I2C register-read target; I2C_TARGET_WRITE_EN adds register writes
import i2c_pkg::*;
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_ptr,
    input  logic [7:0] reg_rdata,
    output logic       rd_stb,
    output logic [7:0] wr_data,
    output logic       wr_stb,
    output logic       busy,
    output logic       addr_hit
);
    logic             sda, scl_rise, scl_fall, start, stop;
    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       shift, shift_d, ptr_d, rx_byte;
    logic             oe_d, busy_d, rd_d, hit_d, match;

    i2c_line_sync u_sync (
        .clk(clk), .rstn(rstn), .scl_in(scl_in), .sda_in(sda_in),
        .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
    );

    assign rx_byte = {shift[6:0], sda};
    assign match   = rx_byte[7:1] == TARGET_ADDR;

`ifdef I2C_TARGET_WRITE_EN
    logic [7:0] wd_q, wd_d;
    logic       ws_q, ws_d;
    assign wr_data = wd_q;
    assign wr_stb  = ws_q;
`else
    assign wr_data = 8'h00;
    assign wr_stb  = 1'b0;
`endif

    // next-state logic; in ACK slots the current sda_oe tells first (assert) from second (end) scl_fall
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shift_d = shift;
        oe_d    = sda_oe;
        ptr_d   = reg_ptr;
        busy_d  = busy;
        rd_d    = 1'b0;
        hit_d   = 1'b0;
`ifdef I2C_TARGET_WRITE_EN
        wd_d    = wd_q;
        ws_d    = 1'b0;
`endif
        if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt + 1'b1;
                    if (&cnt) begin
                        hit_d   = match;
                        busy_d  = match;
                        state_d = match ? ADDR_ACK : IDLE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    oe_d = ~sda_oe;
                    if (sda_oe) begin
                        if (shift[0] == I2C_READ) begin
                            shift_d = reg_rdata;
                            oe_d    = ~reg_rdata[7];
                            rd_d    = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = REG;
                        end
                    end
                end
                REG: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt + 1'b1;
                    if (&cnt) begin
                        ptr_d   = rx_byte;
                        state_d = REG_ACK;
                    end
                end
                REG_ACK: if (scl_fall) begin
                    oe_d = ~sda_oe;
`ifdef I2C_TARGET_WRITE_EN
                    if (sda_oe) state_d = WDATA;
`else
                    // IDLE with busy kept high ignores (NACKs) further bytes until START/STOP
                    if (sda_oe) state_d = IDLE;
`endif
                end
`ifdef I2C_TARGET_WRITE_EN
                WDATA: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt + 1'b1;
                    if (&cnt) begin
                        wd_d    = rx_byte;
                        ws_d    = 1'b1;
                        state_d = WDATA_ACK;
                    end
                end
                WDATA_ACK: if (scl_fall) begin
                    oe_d = ~sda_oe;
                    if (sda_oe) begin
                        ptr_d   = reg_ptr + 8'd1;
                        state_d = WDATA;
                    end
                end
`endif
                RDATA: if (scl_fall) begin
                    shift_d = {shift[6:0], 1'b0};
                    oe_d    = ~shift[6] & ~(&cnt);
                    cnt_d   = cnt + 1'b1;
                    if (&cnt) state_d = RDATA_ACK;
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            ptr_d = reg_ptr + 8'd1;
                        end
                    end else if (scl_fall) begin
                        shift_d = reg_rdata;
                        oe_d    = ~reg_rdata[7];
                        rd_d    = 1'b1;
                        state_d = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // state and output registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            sda_oe   <= 1'b0;
            reg_ptr  <= '0;
            busy     <= 1'b0;
            rd_stb   <= 1'b0;
            addr_hit <= 1'b0;
`ifdef I2C_TARGET_WRITE_EN
            wd_q     <= '0;
            ws_q     <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            shift    <= shift_d;
            sda_oe   <= oe_d;
            reg_ptr  <= ptr_d;
            busy     <= busy_d;
            rd_stb   <= rd_d;
            addr_hit <= hit_d;
`ifdef I2C_TARGET_WRITE_EN
            wd_q     <= wd_d;
            ws_q     <= ws_d;
`endif
        end
    end
endmodule
